// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / load-use hazard bundle between the pipeline registers and fwd_hazard_unit.
// Latency: n/a (wires only).
// Backpressure: n/a; stall requests travel back to the front end on pc_write/ifid_write/idex_flush.
// Ports: master = pipeline side (drives register ids and control, consumes selects/enables);
//        slave  = fwd_hazard_unit.
// Optional: FWD_STALL_CNT_EN adds the stall_count signal and the CNT_W parameter.
interface fwd_hazard_if #(
    parameter int REG_AW = 3
`ifdef FWD_STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
);
    // ID-stage instruction sources
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    // Producers, youngest first
    logic [REG_AW-1:0] idex_rd;
    logic              idex_reg_write;
    logic              idex_mem_read;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_reg_write;
    logic              exmem_mem_read;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_reg_write;
    logic              mem_ready;
    // Results
    logic [1:0]        alu_src1;
    logic [1:0]        alu_src2;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_flush;
`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_count;
`endif

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used,
        output idex_rd, idex_reg_write, idex_mem_read,
        output exmem_rd, exmem_reg_write, exmem_mem_read,
        output memwb_rd, memwb_reg_write, mem_ready,
        input  alu_src1, alu_src2, pc_write, ifid_write, idex_flush
`ifdef FWD_STALL_CNT_EN
        ,
        input  stall_count
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used,
        input  idex_rd, idex_reg_write, idex_mem_read,
        input  exmem_rd, exmem_reg_write, exmem_mem_read,
        input  memwb_rd, memwb_reg_write, mem_ready,
        output alu_src1, alu_src2, pc_write, ifid_write, idex_flush
`ifdef FWD_STALL_CNT_EN
        ,
        output stall_count
`endif
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Resolves EX operand forwarding in ID and stalls the front end on load-use hazards.
// Latency: ALU selects registered (1 cycle, ID -> EX); pc_write/ifid_write/idex_flush combinational.
// Backpressure: stalls while a load feeding ID is in EX, then until data memory signals mem_ready.
// Ports: clk, rst (async, active-high); hz (fwd_hazard_if.slave) carries ID sources, ID/EX,
//        EX/MEM and MEM/WB destinations/control, mem_ready, and returns alu_src1/2 and enables.
// Optional: FWD_STALL_CNT_EN adds a saturating count of bubble cycles on hz.stall_count.
module fwd_hazard_unit #(
    parameter int REG_AW        = 3,
    parameter int ZERO_REG_HARD = 1,
    parameter int RF_BYPASS     = 1
`ifdef FWD_STALL_CNT_EN
    ,
    parameter int CNT_W         = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    fwd_hazard_if.slave hz
);

    // Select encoding seen by the EX-stage muxes. A producer in ID/EX now sits in EX/MEM
    // when the consumer reaches EX, hence the one-stage shift in naming.
    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_HOLD  = 2'b11;
    // With a write-before-read register file the WB-stage value is already in the RF read.
    localparam logic [1:0] SEL_WB    = (RF_BYPASS != 0) ? SEL_RF : SEL_HOLD;

    typedef enum logic {
        ST_RUN,
        ST_LOAD_WAIT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       stall;
    logic       load_use;
    logic       rs_idex, rs_exmem, rs_memwb;
    logic       rt_idex, rt_exmem, rt_memwb;
    logic [1:0] next_src1;
    logic [1:0] next_src2;
    logic [1:0] alu_src1_q;
    logic [1:0] alu_src2_q;

    function automatic logic hits(input logic [REG_AW-1:0] src, input logic used,
                                  input logic [REG_AW-1:0] rd, input logic wr);
        return used && wr && (rd == src) && !((ZERO_REG_HARD != 0) && (rd == '0));
    endfunction

    // Youngest producer wins.
    function automatic logic [1:0] pick(input logic m_idex, input logic m_exmem, input logic m_memwb);
        if (m_idex)  return SEL_EXMEM;
        if (m_exmem) return SEL_MEMWB;
        if (m_memwb) return SEL_WB;
        return SEL_RF;
    endfunction

    assign rs_idex  = hits(hz.id_rs, hz.id_rs_used, hz.idex_rd,  hz.idex_reg_write);
    assign rs_exmem = hits(hz.id_rs, hz.id_rs_used, hz.exmem_rd, hz.exmem_reg_write);
    assign rs_memwb = hits(hz.id_rs, hz.id_rs_used, hz.memwb_rd, hz.memwb_reg_write);
    assign rt_idex  = hits(hz.id_rt, hz.id_rt_used, hz.idex_rd,  hz.idex_reg_write);
    assign rt_exmem = hits(hz.id_rt, hz.id_rt_used, hz.exmem_rd, hz.exmem_reg_write);
    assign rt_memwb = hits(hz.id_rt, hz.id_rt_used, hz.memwb_rd, hz.memwb_reg_write);

    assign next_src1 = pick(rs_idex, rs_exmem, rs_memwb);
    assign next_src2 = pick(rt_idex, rt_exmem, rt_memwb);

    // Either source hitting the same load yields one hazard, hence one stall sequence.
    assign load_use = hz.idex_mem_read && (rs_idex || rt_idex);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (load_use) state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                // A squashed load (no longer a read in EX/MEM) drops us straight back into
                // RUN behaviour, which may itself detect a fresh hazard this cycle.
                if (!hz.exmem_mem_read) begin
                    state_d = load_use ? ST_LOAD_WAIT : ST_RUN;
                end else if (hz.mem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_RUN:       stall = load_use;
            ST_LOAD_WAIT: stall = hz.exmem_mem_read ? !hz.mem_ready : load_use;
            default:      stall = 1'b0;
        endcase
    end

    assign hz.pc_write   = !stall;
    assign hz.ifid_write = !stall;
    assign hz.idex_flush = stall;

    // A bubble entering EX reads nothing, so its selects go to RF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src1_q <= SEL_RF;
            alu_src2_q <= SEL_RF;
        end else begin
            alu_src1_q <= stall ? SEL_RF : next_src1;
            alu_src2_q <= stall ? SEL_RF : next_src2;
        end
    end

    assign hz.alu_src1 = alu_src1_q;
    assign hz.alu_src2 = alu_src2_q;

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hz.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance plus one with ZERO_REG_HARD=0, RF_BYPASS=0,
// both fed the same stimulus and both checked against a behavioural model each cycle.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic [2:0] id_rs;
        logic [2:0] id_rt;
        logic       rs_used;
        logic       rt_used;
        logic [2:0] idex_rd;
        logic       idex_rw;
        logic       idex_mr;
        logic [2:0] exmem_rd;
        logic       exmem_rw;
        logic       exmem_mr;
        logic [2:0] memwb_rd;
        logic       memwb_rw;
        logic       mem_ready;
    } in_t;

    typedef struct {
        in_t        v;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] a2;
        logic       stall;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fwd_hazard_if #(.REG_AW(3)) if_m ();
    fwd_hazard_if #(.REG_AW(3)) if_a ();

    fwd_hazard_unit u_dut (.clk(clk), .rst(rst), .hz(if_m));
    fwd_hazard_unit #(.ZERO_REG_HARD(0), .RF_BYPASS(0)) u_alt (.clk(clk), .rst(rst), .hz(if_a));

    assign if_a.id_rs           = if_m.id_rs;
    assign if_a.id_rt           = if_m.id_rt;
    assign if_a.id_rs_used      = if_m.id_rs_used;
    assign if_a.id_rt_used      = if_m.id_rt_used;
    assign if_a.idex_rd         = if_m.idex_rd;
    assign if_a.idex_reg_write  = if_m.idex_reg_write;
    assign if_a.idex_mem_read   = if_m.idex_mem_read;
    assign if_a.exmem_rd        = if_m.exmem_rd;
    assign if_a.exmem_reg_write = if_m.exmem_reg_write;
    assign if_a.exmem_mem_read  = if_m.exmem_mem_read;
    assign if_a.memwb_rd        = if_m.memwb_rd;
    assign if_a.memwb_reg_write = if_m.memwb_reg_write;
    assign if_a.mem_ready       = if_m.mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Model: per instance, whether the previous cycle was a bubble and the bubble count.
    bit ZH  [2] = '{1'b1, 1'b0};
    bit BYP [2] = '{1'b1, 1'b0};
    bit m_wait [2];
    int m_cnt  [2];
    logic cap_pc [2];
    logic cap_ifid [2];
    logic cap_flush [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs, input int rt, input bit rsu, input bit rtu,
                               input int xrd, input bit xw, input bit xm,
                               input int mrd, input bit mw, input bit mm,
                               input int wrd, input bit ww, input bit rdy);
        in_t v;
        v.id_rs = 3'(rs);   v.id_rt = 3'(rt);   v.rs_used = rsu;  v.rt_used = rtu;
        v.idex_rd = 3'(xrd);  v.idex_rw = xw;  v.idex_mr = xm;
        v.exmem_rd = 3'(mrd); v.exmem_rw = mw; v.exmem_mr = mm;
        v.memwb_rd = 3'(wrd); v.memwb_rw = ww; v.mem_ready = rdy;
        return v;
    endfunction

    // Scan producers youngest first; the code is where that value lives when the consumer is in EX.
    function automatic logic [1:0] ref_sel(input logic [2:0] s, input logic used, input in_t v,
                                           input bit zh, input bit byp);
        logic [2:0] rd   [3];
        logic       wr   [3];
        logic [1:0] code [3];
        rd[0] = v.idex_rd;  rd[1] = v.exmem_rd;  rd[2] = v.memwb_rd;
        wr[0] = v.idex_rw;  wr[1] = v.exmem_rw;  wr[2] = v.memwb_rw;
        code[0] = 2'b10;    code[1] = 2'b01;     code[2] = byp ? 2'b00 : 2'b11;
        for (int p = 0; p < 3; p++) begin
            if (used && wr[p] && rd[p] == s && !(zh && rd[p] == 3'd0)) return code[p];
        end
        return 2'b00;
    endfunction

    function automatic bit ref_stall(input int i, input in_t v);
        bit haz;
        haz = v.idex_mr && (ref_sel(v.id_rs, v.rs_used, v, ZH[i], BYP[i]) == 2'b10 ||
                            ref_sel(v.id_rt, v.rt_used, v, ZH[i], BYP[i]) == 2'b10);
        // Waiting on a load that is still a read: bubble until memory answers.
        if (m_wait[i] && v.exmem_mr) return !v.mem_ready;
        return haz;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wait[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic drive(input in_t v);
        if_m.id_rs = v.id_rs;           if_m.id_rt = v.id_rt;
        if_m.id_rs_used = v.rs_used;    if_m.id_rt_used = v.rt_used;
        if_m.idex_rd = v.idex_rd;       if_m.idex_reg_write = v.idex_rw;
        if_m.idex_mem_read = v.idex_mr;
        if_m.exmem_rd = v.exmem_rd;     if_m.exmem_reg_write = v.exmem_rw;
        if_m.exmem_mem_read = v.exmem_mr;
        if_m.memwb_rd = v.memwb_rd;     if_m.memwb_reg_write = v.memwb_rw;
        if_m.mem_ready = v.mem_ready;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input in_t v);
        bit         st [2];
        logic [1:0] e1 [2];
        logic [1:0] e2 [2];
        drive(v);
        #1;
        cap_pc[0] = if_m.pc_write;   cap_ifid[0] = if_m.ifid_write;  cap_flush[0] = if_m.idex_flush;
        cap_pc[1] = if_a.pc_write;   cap_ifid[1] = if_a.ifid_write;  cap_flush[1] = if_a.idex_flush;
        for (int i = 0; i < 2; i++) begin
            st[i] = ref_stall(i, v);
            e1[i] = st[i] ? 2'b00 : ref_sel(v.id_rs, v.rs_used, v, ZH[i], BYP[i]);
            e2[i] = st[i] ? 2'b00 : ref_sel(v.id_rt, v.rt_used, v, ZH[i], BYP[i]);
            chk($sformatf("pc_write[%0d]", i),   32'(cap_pc[i]),    32'(!st[i]));
            chk($sformatf("ifid_write[%0d]", i), 32'(cap_ifid[i]),  32'(!st[i]));
            chk($sformatf("idex_flush[%0d]", i), 32'(cap_flush[i]), 32'(st[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_wait[i] = st[i];
            if (st[i] && m_cnt[i] < 65535) m_cnt[i]++;
        end
        #1;
        chk("alu_src1[0]", 32'(if_m.alu_src1), 32'(e1[0]));
        chk("alu_src2[0]", 32'(if_m.alu_src2), 32'(e2[0]));
        chk("alu_src1[1]", 32'(if_a.alu_src1), 32'(e1[1]));
        chk("alu_src2[1]", 32'(if_a.alu_src2), 32'(e2[1]));
`ifdef FWD_STALL_CNT_EN
        chk("stall_count[0]", 32'(if_m.stall_count), 32'(m_cnt[0]));
        chk("stall_count[1]", 32'(if_a.stall_count), 32'(m_cnt[1]));
`endif
        @(negedge clk);
    endtask

    function automatic in_t rnd_vec();
        in_t v;
        v.id_rs     = 3'($urandom_range(0, 3));
        v.id_rt     = 3'($urandom_range(0, 3));
        v.rs_used   = ($urandom_range(0, 3) != 0);
        v.rt_used   = ($urandom_range(0, 3) != 0);
        v.idex_rd   = 3'($urandom_range(0, 3));
        v.idex_rw   = ($urandom_range(0, 3) != 0);
        v.idex_mr   = ($urandom_range(0, 2) == 0);
        v.exmem_rd  = 3'($urandom_range(0, 3));
        v.exmem_rw  = ($urandom_range(0, 1) != 0);
        v.exmem_mr  = ($urandom_range(0, 3) != 0);
        v.memwb_rd  = 3'($urandom_range(0, 3));
        v.memwb_rw  = ($urandom_range(0, 1) != 0);
        v.mem_ready = ($urandom_range(0, 1) != 0);
        return v;
    endfunction

    vec_t tab [9];

    initial begin
        in_t idle;
        in_t ld_a;
        in_t ld_w;
        int  bubbles;
        checks   = 0;
        failures = 0;
        idle     = '0;

        // Directed single-cycle vectors from RUN: inputs, main src1/src2, alt src2, stall.
        tab[0] = '{mk(3,0,1,0, 3,1,0, 3,1,0, 0,0, 0), 2'b10, 2'b00, 2'b00, 1'b0};
        tab[1] = '{mk(0,5,0,1, 0,0,0, 0,0,0, 5,1, 0), 2'b00, 2'b00, 2'b11, 1'b0};
        tab[2] = '{mk(1,0,1,0, 0,0,0, 1,1,0, 1,1, 0), 2'b01, 2'b00, 2'b00, 1'b0};
        tab[3] = '{mk(6,0,0,0, 6,1,0, 0,0,0, 0,0, 0), 2'b00, 2'b00, 2'b00, 1'b0};
        tab[4] = '{mk(0,7,0,1, 7,0,0, 7,1,0, 0,0, 0), 2'b00, 2'b01, 2'b01, 1'b0};
        tab[5] = '{mk(2,2,1,1, 0,0,0, 0,0,0, 2,1, 0), 2'b00, 2'b00, 2'b11, 1'b0};
        tab[6] = '{mk(4,0,1,0, 0,0,0, 4,1,1, 0,0, 0), 2'b01, 2'b00, 2'b00, 1'b0};
        tab[7] = '{mk(0,0,0,1, 0,0,0, 0,1,0, 0,0, 0), 2'b00, 2'b00, 2'b01, 1'b0};
        tab[8] = '{mk(5,5,1,1, 5,1,0, 0,0,0, 0,0, 0), 2'b10, 2'b10, 2'b10, 1'b0};

        // Reset state
        rst = 1'b1;
        drive(idle);
        model_reset();
        #2;
        chk("rst alu_src1", 32'(if_m.alu_src1), 32'd0);
        chk("rst alu_src2", 32'(if_m.alu_src2), 32'd0);
        chk("rst pc_write", 32'(if_m.pc_write), 32'd1);
        chk("rst idex_flush", 32'(if_m.idex_flush), 32'd0);
`ifdef FWD_STALL_CNT_EN
        chk("rst stall_count", 32'(if_m.stall_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (tab[k]) begin
            step(tab[k].v);
            chk($sformatf("tab%0d pc_write", k), 32'(cap_pc[0]), 32'(!tab[k].stall));
            chk($sformatf("tab%0d alu_src1", k), 32'(if_m.alu_src1), 32'(tab[k].s1));
            chk($sformatf("tab%0d alu_src2", k), 32'(if_m.alu_src2), 32'(tab[k].s2));
            chk($sformatf("tab%0d alt_src2", k), 32'(if_a.alu_src2), 32'(tab[k].a2));
        end

        // Async reset mid-cycle clears non-zero selects immediately.
        drive(idle);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst alu_src1", 32'(if_m.alu_src1), 32'd0);
        chk("async rst alu_src2", 32'(if_m.alu_src2), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Register 0 load: ignored when hardwired, a real hazard otherwise.
        step(mk(0,0,1,0, 0,1,1, 0,0,0, 0,0, 0));
        chk("zero pc_write", 32'(cap_pc[0]), 32'd1);
        chk("zero alu_src1", 32'(if_m.alu_src1), 32'd0);
        chk("zero alt stalls", 32'(cap_pc[1]), 32'd0);
        step(idle);
        chk("squash alt flush", 32'(cap_flush[1]), 32'd0);

        // Load-use with memory ready at once: single bubble, then forward from MEM/WB.
        ld_a = mk(2,0,1,0, 2,1,1, 0,0,0, 0,0, 0);
        ld_w = mk(2,0,1,0, 0,0,0, 2,1,1, 0,0, 1);
        step(ld_a);
        chk("lu pc_write", 32'(cap_pc[0]), 32'd0);
        chk("lu idex_flush", 32'(cap_flush[0]), 32'd1);
        chk("lu alu_src1", 32'(if_m.alu_src1), 32'd0);
        step(ld_w);
        chk("lu release pc_write", 32'(cap_pc[0]), 32'd1);
        chk("lu release alu_src1", 32'(if_m.alu_src1), 32'd1);
`ifdef FWD_STALL_CNT_EN
        chk("lu stall_count", 32'(if_m.stall_count), 32'd1);
`endif

        // Memory not ready for 3 cycles: 4 bubbles in total.
        step(ld_a);
        bubbles = 1;
        for (int n = 0; n < 10; n++) begin
            ld_w.mem_ready = (n >= 3);
            step(ld_w);
            if (cap_flush[0]) bubbles++;
            else break;
        end
        chk("slow mem bubbles", 32'(bubbles), 32'd4);
        chk("slow mem alu_src1", 32'(if_m.alu_src1), 32'd1);

        // Reset during the second bubble.
        step(ld_a);
        ld_w.mem_ready = 1'b0;
        drive(ld_w);
        #1;
        chk("pre-rst flush", 32'(if_m.idex_flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid-stall rst pc_write", 32'(if_m.pc_write), 32'd1);
        chk("mid-stall rst idex_flush", 32'(if_m.idex_flush), 32'd0);
        chk("mid-stall rst alu_src1", 32'(if_m.alu_src1), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(ld_w);
        chk("post-rst run pc_write", 32'(cap_pc[0]), 32'd1);

        // One load feeding both sources: one stall, both forward on release.
        step(mk(4,4,1,1, 4,1,1, 0,0,0, 0,0, 0));
        chk("both pc_write", 32'(cap_pc[0]), 32'd0);
        step(mk(4,4,1,1, 0,0,0, 4,1,1, 0,0, 1));
        chk("both release pc_write", 32'(cap_pc[0]), 32'd1);
        chk("both alu_src1", 32'(if_m.alu_src1), 32'd1);
        chk("both alu_src2", 32'(if_m.alu_src2), 32'd1);

        for (int n = 0; n < 500; n++) begin
            step(rnd_vec());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding logic.
- Resolves operand forwarding in ID and registers the ALU source selects into EX.
- Detects load-use hazards and runs a stall FSM that tolerates multi-cycle data memory.
- Sits between the ID/EX pipeline register and the ALU input muxes; drives the PC/IF-ID write enables and the ID/EX bubble.

Parameters:
- REG_AW, 3: register address width.
- ZERO_REG_HARD, 1: if 1, register 0 is hardwired zero and never forwards or causes a stall.
- RF_BYPASS, 1: if 1, the register file writes before it reads, so a WB-stage producer needs no forward (select 00). If 0, select 11 is used (WB-hold register).
- CNT_W, 16: stall counter width (optional feature only).

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous reset, active-high
- Id_rs, Id_rt  in  REG_AW  source registers of the instruction in ID
- Id_rs_used, Id_rt_used  in  1  source actually read by the ID instruction
- Idex_rd  in  REG_AW  destination in ID/EX
- Idex_reg_write, Idex_mem_read  in  1  ID/EX control
- Exmem_rd  in  REG_AW  destination in EX/MEM
- Exmem_reg_write, Exmem_mem_read  in  1  EX/MEM control
- Memwb_rd  in  REG_AW  destination in MEM/WB
- Memwb_reg_write  in  1  MEM/WB control
- Mem_ready  in  1  the load in EX/MEM completes this cycle
- Alu_src1, Alu_src2  out  2  registered EX operand select: 00 RF, 10 EX/MEM result, 01 MEM/WB result, 11 WB-hold
- Pc_write, Ifid_write  out  1  front-end advance enables (combinational)
- Idex_flush  out  1  insert a bubble into ID/EX (combinational)
- Stall_count  out  CNT_W  present only with the optional feature

Behaviour:
- Match condition for source s against producer P: s_used && P_reg_write && P_rd==s, and not (ZERO_REG_HARD && P_rd==0).
- Next-select per source, evaluated in ID for the instruction's EX cycle. Priority is youngest first:
  - match Idex -> 10
  - else match Exmem -> 01
  - else match Memwb -> (RF_BYPASS ? 00 : 11)
  - else 00
- Load-use hazard (comb): Idex_mem_read && match Idex on either used source.
- FSM states:
  - RUN:
    - No hazard: Pc_write=Ifid_write=1, Idex_flush=0, Alu_srcN <= next-select.
    - Hazard: Pc_write=Ifid_write=0, Idex_flush=1, Alu_srcN <= 00; go to LOAD_WAIT.
  - LOAD_WAIT (the load is now in EX/MEM):
    - Pc_write=Ifid_write=0, Idex_flush=1, Alu_srcN <= 00 while Mem_ready=0 or Exmem_mem_read=0 is not yet resolved. Exit condition is Mem_ready=1 && Exmem_mem_read=1.
    - On exit: Pc_write=Ifid_write=1, Idex_flush=0, Alu_srcN <= next-select (the load now matches Exmem, so 01); go to RUN.
  - LOAD_WAIT with Exmem_mem_read=0 (load squashed externally): return to RUN immediately and behave as RUN for that cycle.
- Minimum load-use penalty is 1 bubble. With Mem_ready=0 for k cycles, the penalty is 1+k bubbles.
- Hazard on both sources from the same load is a single stall, not two.
- Reset (async, any time, including mid-stall): state=RUN, Alu_src1=Alu_src2=00, Stall_count=0. Comb outputs follow RUN with no hazard.
- Alu_src registers update every cycle; there is no external hold input.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- Defined: Stall_count port exists. It increments by 1 on every cycle with Idex_flush=1, saturates at all-ones, and is cleared only by Rst.
- Undefined: no port, no counter logic. All other behaviour is identical.

Test Plan:
1. Idex_rd=3, Idex_reg_write=1, Idex_mem_read=0, Id_rs=3 used, Exmem_rd=3, Exmem_reg_write=1 -> next cycle Alu_src1=10 (youngest wins), Alu_src2=00, no stall.
2. Memwb_rd=5 write, Id_rt=5 used, no younger match -> Alu_src2=00 with RF_BYPASS=1; 11 with RF_BYPASS=0.
3. ZERO_REG_HARD=1, Idex_rd=0 write with mem_read, Id_rs=0 used -> no stall, Alu_src1=00.
4. Load Idex_rd=2, Id_rs=2 used, Mem_ready=1 -> one cycle of Pc_write=0 and Idex_flush=1, Alu_src1=00. Next cycle Alu_src1=01 and Pc_write=1. Stall_count=1 with the macro defined.
5. Same load with Mem_ready=0 for 3 cycles -> 4 bubbles total, then Alu_src1=01. Assert Rst in the 2nd bubble -> outputs reset immediately, FSM=RUN.
6. Load hits both Id_rs=4 and Id_rt=4 -> single stall sequence; on release Alu_src1=Alu_src2=01.
